// File: rtl/cdc_handshake_sync.sv
// cdc_handshake_sync
//   Moves one DATA_WIDTH-bit word from the clk_src_i domain to the
//   clk_dest_i domain with a four-phase req/ack handshake. req and ack each
//   cross through a CHAIN_LENGTH-flop synchronizer. The data word is held
//   stable in the source domain while req is high, so the destination can
//   sample it without its own synchronizer. Each domain has its own 2-flop
//   reset synchronizer, fed by the shared raw reset_ni. This gives
//   asynchronous assertion and synchronous release in each domain.
module cdc_handshake_sync #(
    parameter int unsigned CHAIN_LENGTH = 3,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                  clk_src_i,
    input  logic                  clk_dest_i,
    input  logic                  reset_ni,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    // ------------------------------------------------------------------
    // Reset synchronizers
    // ------------------------------------------------------------------
    logic [1:0] src_rst_q;
    logic [1:0] src_rst_d;
    logic [1:0] dest_rst_q;
    logic [1:0] dest_rst_d;
    logic       src_rst_n;
    logic       dest_rst_n;

    // Shift a constant 1 into each reset chain.
    always_comb begin
        src_rst_d  = {src_rst_q[0], 1'b1};
        dest_rst_d = {dest_rst_q[0], 1'b1};
    end

    // Source reset sync: clears asynchronously, releases on the 2nd clk_src_i edge.
    always_ff @(posedge clk_src_i or negedge reset_ni) begin
        if (!reset_ni) begin
            src_rst_q <= '0;
        end else begin
            src_rst_q <= src_rst_d;
        end
    end

    // Destination reset sync: clears asynchronously, releases on the 2nd clk_dest_i edge.
    always_ff @(posedge clk_dest_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dest_rst_q <= '0;
        end else begin
            dest_rst_q <= dest_rst_d;
        end
    end

    assign src_rst_n  = src_rst_q[1];
    assign dest_rst_n = dest_rst_q[1];

    // ------------------------------------------------------------------
    // Source domain
    // ------------------------------------------------------------------
    logic                    req_q;
    logic                    req_d;
    logic [DATA_WIDTH-1:0]   hold_q;
    logic [DATA_WIDTH-1:0]   hold_d;
    logic [CHAIN_LENGTH-1:0] ack_chain_q;
    logic [CHAIN_LENGTH-1:0] ack_chain_d;
    logic                    ack_sync;
    logic                    accept;

    // ------------------------------------------------------------------
    // Destination domain
    // ------------------------------------------------------------------
    logic [CHAIN_LENGTH-1:0] req_chain_q;
    logic [CHAIN_LENGTH-1:0] req_chain_d;
    logic                    req_sync;
    logic                    req_sync_dly_q;
    logic                    req_sync_dly_d;
    logic                    valid_q;
    logic                    valid_d;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   data_d;

    assign ack_sync = ack_chain_q[CHAIN_LENGTH-1];
    assign req_sync = req_chain_q[CHAIN_LENGTH-1];

    // busy covers the whole handshake. It spans from req rising until the
    // returned ack has fallen again, so the source cannot start a new word
    // before the destination has seen req drop.
    assign busy_o = req_q | ack_sync;
    assign accept = valid_i & ~busy_o;

    // Source next state: capture the word on acceptance, drop req once ack returns.
    always_comb begin
        req_d       = req_q;
        hold_d      = hold_q;
        ack_chain_d = {ack_chain_q[CHAIN_LENGTH-2:0], req_sync};
        if (ack_sync) begin
            req_d = 1'b0;
        end else if (accept) begin
            req_d  = 1'b1;
            hold_d = data_i;
        end
    end

    // Source registers: req, held word and ack synchronizer chain.
    always_ff @(posedge clk_src_i or negedge src_rst_n) begin
        if (!src_rst_n) begin
            req_q       <= 1'b0;
            hold_q      <= '0;
            ack_chain_q <= '0;
        end else begin
            req_q       <= req_d;
            hold_q      <= hold_d;
            ack_chain_q <= ack_chain_d;
        end
    end

    // Destination next state: detect the rising edge of the synchronized req.
    // On that edge, take a one-cycle strobe and sample the held word.
    always_comb begin
        req_chain_d    = {req_chain_q[CHAIN_LENGTH-2:0], req_q};
        req_sync_dly_d = req_sync;
        valid_d        = req_sync & ~req_sync_dly_q;
        data_d         = data_q;
        if (valid_d) begin
            data_d = hold_q;
        end
    end

    // Destination registers: req synchronizer chain, edge detector, outputs.
    always_ff @(posedge clk_dest_i or negedge dest_rst_n) begin
        if (!dest_rst_n) begin
            req_chain_q    <= '0;
            req_sync_dly_q <= 1'b0;
            valid_q        <= 1'b0;
            data_q         <= '0;
        end else begin
            req_chain_q    <= req_chain_d;
            req_sync_dly_q <= req_sync_dly_d;
            valid_q        <= valid_d;
            data_q         <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_cdc_handshake_sync.sv
// Directed bench for cdc_handshake_sync. It uses a 10 ns source clock and
// a 64 ns destination clock.
module tb_cdc_handshake_sync;

    localparam int unsigned CL = 3;
    localparam int unsigned DW = 32;

    logic          clk_src_i;
    logic          clk_dest_i;
    logic          reset_ni;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          busy_o;
    logic          valid_o;
    logic [DW-1:0] data_o;

    int errors;
    int checks;

    int          dest_edges;
    int          pulse_cnt;
    int          pulse_edge;
    int          multi_cyc;
    logic        prev_v;
    logic [31:0] pulse_data;
    int          acc_edge;

    cdc_handshake_sync #(.CHAIN_LENGTH(CL), .DATA_WIDTH(DW)) dut (
        .clk_src_i (clk_src_i),
        .clk_dest_i(clk_dest_i),
        .reset_ni  (reset_ni),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .data_o    (data_o)
    );

    initial begin
        clk_src_i = 1'b0;
        forever #5 clk_src_i = ~clk_src_i;
    end

    initial begin
        clk_dest_i = 1'b0;
        forever #32 clk_dest_i = ~clk_dest_i;
    end

    always @(posedge clk_dest_i) dest_edges++;

    // Pulse monitor, sampled mid-cycle on the destination clock.
    always @(negedge clk_dest_i) begin
        if (valid_o === 1'b1) begin
            pulse_cnt++;
            pulse_data = data_o;
            pulse_edge = dest_edges;
            if (prev_v === 1'b1) multi_cyc++;
        end
        prev_v = valid_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one word for one source cycle and check busy rises on that edge.
    task automatic send(input logic [31:0] d, input string tag);
        @(negedge clk_src_i);
        valid_i = 1'b1;
        data_i  = d;
        @(posedge clk_src_i);
        #1;
        acc_edge = dest_edges;
        check({tag, "_busy_rise"}, {31'd0, busy_o}, 32'd1);
        @(negedge clk_src_i);
        valid_i = 1'b0;
    endtask

    task automatic wait_pulse(input int target, input string tag);
        int n;
        n = 0;
        while (pulse_cnt < target && n < 40) begin
            @(negedge clk_dest_i);
            n++;
        end
        if (pulse_cnt < target) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed=%0d expected=%0d pulses", tag, pulse_cnt, target);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < 400) begin
            @(posedge clk_src_i);
            #1;
            n++;
        end
        check({tag, "_busy_fall"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int base;
        int lat;
        errors     = 0;
        checks     = 0;
        dest_edges = 0;
        pulse_cnt  = 0;
        pulse_edge = 0;
        multi_cyc  = 0;
        prev_v     = 1'b0;
        pulse_data = '0;
        acc_edge   = 0;
        reset_ni   = 1'b0;
        valid_i    = 1'b0;
        data_i     = '0;

        // Reset state.
        #50;
        check("rst_busy",  {31'd0, busy_o},  32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_data",  data_o,           32'd0);
        #50 reset_ni = 1'b1;                  // t=100
        // Source posedges are at 105 and 115; destination posedges at 160 and 224.
        #10 check("src_rst_1edge",  {31'd0, dut.src_rst_n},  32'd0);   // t=110
        #6  check("src_rst_2edge",  {31'd0, dut.src_rst_n},  32'd1);   // t=116
        #84 check("dest_rst_1edge", {31'd0, dut.dest_rst_n}, 32'd0);   // t=200
        #30 check("dest_rst_2edge", {31'd0, dut.dest_rst_n}, 32'd1);   // t=230
        check("idle_pulses", pulse_cnt, 32'd0);

        // Single transfer with latency check.
        send(32'h0000_1ced, "single");
        wait_pulse(1, "single");
        lat = pulse_edge - acc_edge;
        check("single_data", pulse_data, 32'h0000_1ced);
        check("single_latency_ok", {31'd0, (lat >= CL + 1) && (lat <= CL + 2)}, 32'd1);
        wait_idle("single");
        check("single_one_pulse", pulse_cnt, 32'd1);

        // Valid held for 10 source cycles gives exactly one transfer.
        @(negedge clk_src_i);
        valid_i = 1'b1;
        data_i  = 32'h0000_1ced;
        repeat (10) @(negedge clk_src_i);
        valid_i = 1'b0;
        wait_pulse(2, "held");
        wait_idle("held");
        #400;
        check("held_one_pulse", pulse_cnt, 32'd2);
        check("held_data", data_o, 32'h0000_1ced);

        // Back-to-back word; data_i changes while busy must not leak through.
        send(32'h00c0_ffee, "b2b");
        data_i = 32'hdead_beef;
        wait_pulse(3, "b2b");
        check("b2b_data", pulse_data, 32'h00c0_ffee);
        wait_idle("b2b");
        #500;
        check("b2b_hold", data_o, 32'h00c0_ffee);
        check("b2b_pulses", pulse_cnt, 32'd3);
        check("strobe_width", multi_cyc, 32'd0);

        // Reset mid-transfer aborts the word.
        send(32'h1234_5678, "abort");
        #60;
        reset_ni = 1'b0;
        #20;
        check("abort_busy",  {31'd0, busy_o},  32'd0);
        check("abort_valid", {31'd0, valid_o}, 32'd0);
        check("abort_data",  data_o,           32'd0);
        #30 reset_ni = 1'b1;
        #800;
        check("abort_no_pulse", pulse_cnt, 32'd3);
        check("abort_data_after", data_o, 32'd0);
        base = pulse_cnt;

        send(32'ha5a5_a5a5, "post");
        wait_pulse(base + 1, "post");
        check("post_data", pulse_data, 32'ha5a5_a5a5);
        wait_idle("post");
        check("post_hold", data_o, 32'ha5a5_a5a5);
        check("final_strobe_width", multi_cyc, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
